// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit in front of a word-wide DMEM; SB/SH are done as read-modify-write.
// Optional macro LSU_BOUNDS_CHECK_EN flags addresses beyond the DMEM depth instead of aliasing them.
module lsu_ctrl #(
    parameter int DMEM_AW = 5,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            dmem_we,
    input  logic [XLEN-1:0] dmem_rdata
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_ST_WORD = 3'd2,
        S_RMW_RD  = 3'd3,
        S_RMW_WR  = 3'd4,
        S_RESP    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [DMEM_AW+1:0] addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic               dmem_we_q, dmem_we_d;
    logic [XLEN-1:0]    dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]    dmem_wdata_q, dmem_wdata_d;
    logic               illegal_s, misaligned_s, out_of_range_s;

    function automatic logic [XLEN-1:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                                    input logic [XLEN-1:0] word);
        logic [7:0]      b_v;
        logic [15:0]     h_v;
        logic [XLEN-1:0] res;
        b_v = 8'(word >> {off, 3'b000});
        h_v = 16'(word >> {off[1], 4'b0000});
        case (f3)
            3'd0:    res = {{(XLEN-8){b_v[7]}}, b_v};
            3'd1:    res = {{(XLEN-16){h_v[15]}}, h_v};
            3'd4:    res = {{(XLEN-8){1'b0}}, b_v};
            3'd5:    res = {{(XLEN-16){1'b0}}, h_v};
            default: res = word;
        endcase
        return res;
    endfunction

    // Sub-word store data replaces only its byte/half lane of the word read back
    function automatic logic [XLEN-1:0] merge_store(input logic [2:0] f3, input logic [1:0] off,
                                                    input logic [XLEN-1:0] word,
                                                    input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] mask_v, data_v;
        logic [4:0]      sh_v;
        if (f3 == 3'd0) begin
            sh_v   = {off, 3'b000};
            mask_v = {{(XLEN-8){1'b0}}, 8'hFF};
            data_v = {{(XLEN-8){1'b0}}, wd[7:0]};
        end else begin
            sh_v   = {off[1], 4'b0000};
            mask_v = {{(XLEN-16){1'b0}}, 16'hFFFF};
            data_v = {{(XLEN-16){1'b0}}, wd[15:0]};
        end
        return (word & ~(mask_v << sh_v)) | (data_v << sh_v);
    endfunction

    // Request decode: illegal funct3, misalignment and optional range check
    always_comb begin
        if (req_we) begin
            illegal_s = (req_funct3 > 3'd2);
        end else begin
            illegal_s = (req_funct3 == 3'd3) || (req_funct3 > 3'd5);
        end
        case (req_funct3[1:0])
            2'd1:    misaligned_s = req_addr[0];
            2'd2:    misaligned_s = (req_addr[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
`ifdef LSU_BOUNDS_CHECK_EN
        out_of_range_s = |req_addr[XLEN-1:DMEM_AW+2];
`else
        out_of_range_s = 1'b0;
`endif
    end

`ifndef LSU_BOUNDS_CHECK_EN
    // Upper address bits alias onto the DMEM word index when unchecked
    logic unused_addr_s;
    assign unused_addr_s = |req_addr[XLEN-1:DMEM_AW+2];
`endif

    // Next-state, captured request and registered-output computation
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr[DMEM_AW+1:0];
                    wdata_d  = req_wdata;
                    rdata_d  = {XLEN{1'b0}};
                    err_d    = 1'b0;
                    if (illegal_s || misaligned_s || out_of_range_s) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_funct3 == 3'd2) begin
                        state_d = S_ST_WORD;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                rdata_d = format_load(funct3_q, addr_q[1:0], dmem_rdata);
                state_d = S_RESP;
            end
            S_ST_WORD: state_d = S_RESP;
            S_RMW_RD: begin
                wdata_d = merge_store(funct3_q, addr_q[1:0], dmem_rdata, wdata_q);
                state_d = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    rdata_d = {XLEN{1'b0}};
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they align with state_q
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        dmem_we_d    = (state_d == S_ST_WORD) || (state_d == S_RMW_WR);
        if (state_d == S_IDLE) begin
            dmem_addr_d = {XLEN{1'b0}};
        end else begin
            dmem_addr_d = {{(XLEN-DMEM_AW){1'b0}}, addr_d[DMEM_AW+1:2]};
        end
        if (dmem_we_d) begin
            dmem_wdata_d = wdata_d;
        end else begin
            dmem_wdata_d = {XLEN{1'b0}};
        end
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            funct3_q     <= 3'd0;
            addr_q       <= {(DMEM_AW+2){1'b0}};
            wdata_q      <= {XLEN{1'b0}};
            rdata_q      <= {XLEN{1'b0}};
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= {XLEN{1'b0}};
            dmem_wdata_q <= {XLEN{1'b0}};
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a word-array DMEM and a request-level reference model.
module tb_lsu_ctrl;
    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_we;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
        .dmem_rdata(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h1111_1111) ^ 32'hA5A5_0F0F;
    endfunction

    // DMEM: combinational read, word write on the clock edge
    logic [31:0] mem [0:31];
    logic        mem_load;
    assign dmem_rdata = mem[dmem_addr[4:0]];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
        end else if (dmem_we) begin
            mem[dmem_addr[4:0]] <= dmem_wdata;
        end
    end

    int          errors = 0, checks = 0;
    logic [31:0] ref_mem [0:31];
    logic [31:0] exp_rdata, exp_widx, exp_wdata, last_rdata;
    logic        exp_err;
    int          exp_lat, exp_we_cnt, total_we = 0, we_base, req_id = 0, seen_id = 0;
    bit          pending = 1'b0, manual = 1'b0;
    time         acc_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model's expectation
    always @(negedge clk) begin
        if (dmem_we) total_we++;
        if (pending) begin
            chk("dmem_addr_busy", dmem_addr, exp_widx);
            if (dmem_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
            if (resp_valid) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
                chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
                if (seen_id != req_id) begin
                    seen_id = req_id;
                    chk("latency", 32'((($time - acc_t) + 5) / 10), exp_lat);
                    chk("we_count", total_we - we_base, exp_we_cnt);
                    last_rdata = resp_rdata;
                end
            end
        end else if (!manual && rst_n) begin
            chk("idle_we", {31'd0, dmem_we}, 32'd0);
            chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("idle_dmem_addr", dmem_addr, 32'd0);
        end
    end

    // Issue one request, predict its response from the ISA rules, wait for the handshake
    task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold);
        logic [31:0] w, nw;
        int off, v, sh;
        bit bad, got;
        off = int'(addr[1:0]);
        w   = ref_mem[addr[6:2]];
        bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
        if (f3[1:0] == 2'd1 && addr[0]) bad = 1'b1;
        if (f3[1:0] == 2'd2 && addr[1:0] != 2'd0) bad = 1'b1;
`ifdef LSU_BOUNDS_CHECK_EN
        if (addr[31:7] != 25'd0) bad = 1'b1;
`endif
        exp_err = bad; exp_rdata = 32'd0; exp_we_cnt = 0; exp_wdata = 32'd0;
        exp_widx = {27'd0, addr[6:2]};
        if (bad) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat = 2;
            if (f3 == 3'd0 || f3 == 3'd4) begin
                v = int'((w >> (8 * off)) & 32'hFF);
                if (f3 == 3'd0 && v > 127) v = v - 256;
                exp_rdata = v;
            end else if (f3 == 3'd1 || f3 == 3'd5) begin
                v = int'((w >> (16 * (off / 2))) & 32'hFFFF);
                if (f3 == 3'd1 && v > 32767) v = v - 65536;
                exp_rdata = v;
            end else begin
                exp_rdata = w;
            end
        end else begin
            exp_we_cnt = 1;
            if (f3 == 3'd2) begin
                exp_lat = 2; nw = wd;
            end else if (f3 == 3'd0) begin
                exp_lat = 3; sh = 8 * off;
                nw = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            end else begin
                exp_lat = 3; sh = 16 * (off / 2);
                nw = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            end
            exp_wdata = nw;
            ref_mem[addr[6:2]] = nw;
        end
        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        resp_ready = (hold == 0);
        @(posedge clk);
        acc_t = $time; we_base = total_we;
        #1;
        req_valid = 1'b0; req_id++; pending = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk); #1;
            if (resp_valid) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL resp_timeout: no resp_valid within 20 cycles, addr %h", addr);
        end
        repeat (hold) @(negedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 pending = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mem_load = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
        last_rdata = 32'd0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        mem_load = 1'b0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Reset while an SB sits in RMW_RD: the write must be abandoned
        manual = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h11; req_wdata = 32'h77;
        @(posedge clk); #1 req_valid = 1'b0;
        we_base = total_we;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_dmem_we", {31'd0, dmem_we}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_write", total_we - we_base, 32'd0);
        chk("midrst_mem_intact", mem[4], init_word(4));
        manual = 1'b0;

        send(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        send(1'b0, 3'd2, 32'h10, 32'h0, 0);
        chk("lw_0x10_lit", last_rdata, 32'hDEADBEEF);
        send(1'b1, 3'd0, 32'h11, 32'h0000_0055, 0);
        chk("model_sb_word4", ref_mem[4], 32'hDEAD55EF);
        send(1'b0, 3'd2, 32'h10, 32'h0, 0);
        chk("lw_after_sb_lit", last_rdata, 32'hDEAD55EF);
        send(1'b0, 3'd0, 32'h11, 32'h0, 0);
        chk("lb_0x11_lit", last_rdata, 32'h0000_0055);
        send(1'b0, 3'd4, 32'h13, 32'h0, 0);
        chk("lbu_0x13_lit", last_rdata, 32'h0000_00DE);
        send(1'b0, 3'd0, 32'h13, 32'h0, 0);
        chk("lb_0x13_lit", last_rdata, 32'hFFFF_FFDE);
        send(1'b1, 3'd1, 32'h12, 32'hABCD_8001, 0);
        send(1'b0, 3'd1, 32'h12, 32'h0, 0);
        chk("lh_0x12_lit", last_rdata, 32'hFFFF_8001);
        send(1'b0, 3'd5, 32'h12, 32'h0, 0);
        chk("lhu_0x12_lit", last_rdata, 32'h0000_8001);
        send(1'b0, 3'd2, 32'h10, 32'h0, 0);
        chk("lw_after_sh_lit", last_rdata, 32'h8001_55EF);

        // Lower lanes and other words
        send(1'b1, 3'd1, 32'h20, 32'h0000_7FFE, 0);
        send(1'b0, 3'd1, 32'h20, 32'h0, 0);
        send(1'b1, 3'd0, 32'h22, 32'hFFFF_FF80, 0);
        send(1'b0, 3'd0, 32'h22, 32'h0, 0);
        send(1'b0, 3'd2, 32'h20, 32'h0, 0);
        send(1'b0, 3'd5, 32'h7C, 32'h0, 0);

        // Illegal and misaligned requests never touch DMEM
        send(1'b0, 3'd2, 32'h11, 32'h0, 0);
        chk("err_rdata_lit", last_rdata, 32'h0);
        send(1'b1, 3'd1, 32'h13, 32'h1234, 0);
        send(1'b0, 3'd3, 32'h10, 32'h0, 0);
        send(1'b1, 3'd5, 32'h10, 32'h1, 0);
        send(1'b0, 3'd7, 32'h10, 32'h0, 0);
        send(1'b0, 3'd5, 32'h01, 32'h0, 0);

        // Backpressure: response held for 5 cycles must stay stable
        send(1'b0, 3'd2, 32'h10, 32'h0, 5);
        chk("bp_lw_lit", last_rdata, 32'h8001_55EF);

        // Upper address bits: alias onto word 0 / 1, or error when bounds checking
        send(1'b0, 3'd2, 32'h80, 32'h0, 0);
`ifdef LSU_BOUNDS_CHECK_EN
        chk("lw_0x80_lit", last_rdata, 32'h0);
`else
        chk("lw_0x80_lit", last_rdata, 32'hA5A5_0F0F);
`endif
        send(1'b1, 3'd2, 32'h104, 32'h0BAD_F00D, 0);
        send(1'b0, 3'd2, 32'h04, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit sitting directly upstream of the 32-word data memory in the RV32I core. It accepts one load or store request at a time from the execute stage and performs the DMEM access.
- Sub-word stores use read-modify-write, since DMEM has word-wide write enable only.
- Loads are byte/half extracted and sign- or zero-extended.
- Misaligned and illegal accesses are flagged.

Parameters:
DMEM_AW, 5, log2 of DMEM depth in words; word index = req_addr[DMEM_AW+1:2]
XLEN, 32, data width of core and DMEM

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept; high only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (LB0 LH1 LW2 LBU4 LHU5 / SB0 SH1 SW2)
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data (low bits used for SB/SH)
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  XLEN  formatted load data; 0 for stores and errors
resp_err  out  1  misaligned/illegal access
dmem_addr  out  XLEN  word index to DMEM, zero-extended
dmem_wdata  out  XLEN  word to write
dmem_we  out  1  DMEM write enable
dmem_rdata  in  XLEN  DMEM combinational read data

Behaviour:
- Reset (async, any state): FSM->IDLE; all outputs 0 except req_ready=1; captured regs cleared. A store in progress is abandoned and no dmem_we is issued.
- States: IDLE, LOAD, ST_WORD, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready=1. On req_valid, capture we/funct3/addr/wdata and decode:
  - illegal funct3 (load 3,6,7; store 3-7) -> RESP with err=1;
  - misaligned (H: addr[0]!=0; W: addr[1:0]!=0) -> RESP with err=1;
  - load -> LOAD; SW -> ST_WORD; SB/SH -> RMW_RD.
- LOAD: dmem_addr=word index. At clock edge, latch the formatted result -> RESP.
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
- ST_WORD: dmem_we=1, dmem_wdata=wdata -> RESP.
- RMW_RD: read word; merge wdata[7:0] into byte lane addr[1:0] (SB) or wdata[15:0] into half lane addr[1] (SH); latch merged word -> RMW_WR.
- RMW_WR: dmem_we=1, dmem_wdata=merged -> RESP.
- RESP: resp_valid=1; resp_rdata/resp_err stable until resp_ready. On resp_valid&&resp_ready -> IDLE. No new request is accepted in the same cycle.
- dmem_we is high only in ST_WORD/RMW_WR, exactly one cycle per store. Errored requests never touch DMEM.
- dmem_addr holds the captured word index in every non-IDLE state; 0 in IDLE.
- Latency, accept edge to resp_valid: error 1 cycle, load/SW 2 cycles, SB/SH 3 cycles.
- Throughput is one outstanding request. Back-to-back requests need a minimum of one IDLE cycle between them.
- Address bits above DMEM_AW+1 are ignored (aliasing) unless the optional feature is enabled.

Optional Feature:
LSU_BOUNDS_CHECK_EN
- Defined: a request with any of req_addr[XLEN-1:DMEM_AW+2] nonzero is flagged in IDLE: err=1, no DMEM access, 1-cycle latency. Error priority: illegal funct3 > misaligned > out of range.
- Undefined: upper address bits are ignored and the access wraps onto word index addr[DMEM_AW+1:2].

Test Plan:
- Reset mid-RMW: reset asserted in RMW_RD -> dmem_we never pulses; req_ready=1 and resp_valid=0 immediately after reset.
- SW addr=0x10, data 0xDEADBEEF, then LW 0x10 -> dmem_we one cycle at index 4; load resp_rdata=0xDEADBEEF, err=0, 2-cycle latency.
- Word 4=0xDEADBEEF; SB addr=0x11 data 0x55 -> word 4 becomes 0xDEAD55EF; then LB 0x11 returns 0x00000055; LBU 0x13 returns 0x000000DE; LB 0x13 returns 0xFFFFFFDE.
- SH addr=0x12 data 0x8001 -> word 4 upper half = 0x8001; LH 0x12 returns 0xFFFF8001; LHU 0x12 returns 0x00008001.
- LW addr=0x11, SH addr=0x13, load funct3=3 -> each returns err=1, rdata=0 after 1 cycle; dmem_we stays 0.
- Response backpressure: hold resp_ready=0 for 5 cycles after a load -> resp_valid/resp_rdata stable, req_ready=0. With LSU_BOUNDS_CHECK_EN, LW 0x80 returns err=1; without it, LW 0x80 returns word 0.
